// File: rtl/cache_control_two_cycle_if.sv
// CPU-side request/response and physical-memory handshake of the cache controller.
interface cache_control_two_cycle_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;

  // Environment side: CPU requester plus physical memory responder
  modport master (
    output mem_read, mem_write, pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );

  // Controller side
  modport slave (
    input  mem_read, mem_write, pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_control_two_cycle.sv
// Sequencing FSM for a 2-way, two-cycle cache: tag compare, dirty writeback,
// line fill, refetch and PLRU update, plus saturating hit/miss counters.
// Array write enables are active-low. Outputs decode the current state, and in
// COMPARE/FILL also the same-cycle hit/pmem_resp, so an asynchronous reset
// releases pmem_read/pmem_write and all write enables at once.
module cache_control_two_cycle #(
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  cache_control_two_cycle_if.slave bus,
  input  logic                     hit,
  input  logic                     hit_path,
  input  logic                     lru_path,
  input  logic                     lru_valid_bit,
  input  logic                     lru_dirty_bit,
  output logic [1:0]               load_tag_array,
  output logic [1:0]               load_valid_array,
  output logic [1:0]               load_data_array,
  output logic [1:0]               load_dirty_array,
  output logic [1:0]               dirty_input_array,
  output logic                     load_lru,
  output logic                     lru_input,
  output logic                     addr_bit,
  output logic                     data_bit,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    REFETCH   = 3'd4
  } state_t;

  state_t state;
  logic   is_write;

  // A request with both strobes set is handled as a write.
  assign is_write = bus.mem_write;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // State sequencing and saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.mem_read | bus.mem_write) state <= COMPARE;
        end
        COMPARE: begin
          if (hit) begin
            hit_count <= sat_inc(hit_count);
            state     <= IDLE;
          end else begin
            miss_count <= sat_inc(miss_count);
            state      <= (lru_valid_bit & lru_dirty_bit) ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) state <= FILL;
        end
        FILL: begin
          if (bus.pmem_resp) state <= REFETCH;
        end
        REFETCH: begin
          // Re-read the SRAM so the freshly filled line is compared next.
          state <= COMPARE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath controls, handshakes and array write enables
  always_comb begin
    load_tag_array    = 2'b11;
    load_valid_array  = 2'b11;
    load_data_array   = 2'b11;
    load_dirty_array  = 2'b11;
    dirty_input_array = 2'b00;
    load_lru          = 1'b1;
    lru_input         = 1'b0;
    addr_bit          = 1'b0;
    data_bit          = 1'b0;
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    case (state)
      COMPARE: begin
        if (hit) begin
          bus.mem_resp = 1'b1;
          load_lru     = 1'b0;
          lru_input    = hit_path;
          if (is_write) begin
            load_data_array[hit_path]   = 1'b0;
            load_dirty_array[hit_path]  = 1'b0;
            dirty_input_array[hit_path] = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        addr_bit       = 1'b1;
        bus.pmem_write = 1'b1;
      end
      FILL: begin
        bus.pmem_read = 1'b1;
        // The victim way is written only in the cycle the line arrives.
        if (bus.pmem_resp) begin
          data_bit                   = 1'b1;
          load_data_array[lru_path]  = 1'b0;
          load_tag_array[lru_path]   = 1'b0;
          load_valid_array[lru_path] = 1'b0;
          load_dirty_array[lru_path] = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_control_two_cycle.sv
// Bench for cache_control_two_cycle: a one-set, two-way datapath model answers
// hit/lru queries from the controller's own array writes, while a
// transaction-level reference cache builds the expected per-cycle output trace.
module tb_cache_control_two_cycle;
  localparam int CW  = 3;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_control_two_cycle_if bus();

  logic       hit, hit_path, lru_path, lru_valid_bit, lru_dirty_bit;
  logic [1:0] load_tag_array, load_valid_array, load_data_array, load_dirty_array, dirty_input_array;
  logic       load_lru, lru_input, addr_bit, data_bit;
  logic [CW-1:0] hit_count, miss_count;

  cache_control_two_cycle #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .hit(hit), .hit_path(hit_path), .lru_path(lru_path),
    .lru_valid_bit(lru_valid_bit), .lru_dirty_bit(lru_dirty_bit),
    .load_tag_array(load_tag_array), .load_valid_array(load_valid_array),
    .load_data_array(load_data_array), .load_dirty_array(load_dirty_array),
    .dirty_input_array(dirty_input_array), .load_lru(load_lru), .lru_input(lru_input),
    .addr_bit(addr_bit), .data_bit(data_bit),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct packed {
    logic       mem_resp, pmem_read, pmem_write;
    logic [1:0] ld_tag, ld_valid, ld_data, ld_dirty, dirty_in;
    logic       ld_lru, lru_in, addr_bit, data_bit;
  } outv_t;

  typedef struct {
    logic       rd, wr, presp;
    logic [7:0] tag;
    outv_t      o;
    int         h, m;
  } step_t;

  // ---------------- datapath model (stimulus side) ----------------
  logic [7:0] cur_tag;
  logic       dp_clr;
  logic [7:0] dp_tag [2];
  logic [1:0] dp_valid, dp_dirty;
  logic       dp_mru;

  // Single-set arrays written through the controller's active-low enables
  always @(posedge clk) begin
    if (dp_clr) begin
      dp_valid <= '0; dp_dirty <= '0; dp_mru <= 1'b0;
      dp_tag[0] <= '0; dp_tag[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!load_tag_array[i])   dp_tag[i]   <= cur_tag;
        if (!load_valid_array[i]) dp_valid[i] <= 1'b1;
        if (!load_dirty_array[i]) dp_dirty[i] <= dirty_input_array[i];
      end
      if (!load_lru) dp_mru <= lru_input;
    end
  end

  // Tag match and victim lookup for the current request
  always_comb begin
    hit = 1'b0;
    hit_path = 1'b0;
    for (int i = 0; i < 2; i++)
      if (dp_valid[i] && dp_tag[i] == cur_tag) begin
        hit = 1'b1;
        hit_path = i[0];
      end
    lru_path      = ~dp_mru;
    lru_valid_bit = dp_valid[lru_path];
    lru_dirty_bit = dp_dirty[lru_path];
  end

  // ---------------- reference cache and scoreboard ----------------
  logic [7:0] ref_tag [2];
  logic [1:0] ref_valid, ref_dirty;
  logic       ref_mru;
  int         exp_hits, exp_misses;
  step_t      trace[$];
  step_t      cur;
  logic       chk_en;
  int         n_cmp, n_fail;
  int         cyc, req_cyc, last_lat, fill_cyc, resp_gap;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic outv_t dflt();
    outv_t o = '0;
    o.ld_tag = 2'b11; o.ld_valid = 2'b11; o.ld_data = 2'b11; o.ld_dirty = 2'b11;
    o.ld_lru = 1'b1;
    return o;
  endfunction

  function automatic outv_t act_out();
    outv_t o;
    o.mem_resp = bus.mem_resp; o.pmem_read = bus.pmem_read; o.pmem_write = bus.pmem_write;
    o.ld_tag = load_tag_array; o.ld_valid = load_valid_array; o.ld_data = load_data_array;
    o.ld_dirty = load_dirty_array; o.dirty_in = dirty_input_array;
    o.ld_lru = load_lru; o.lru_in = lru_input; o.addr_bit = addr_bit; o.data_bit = data_bit;
    return o;
  endfunction

  function automatic int sat(input int v);
    return (v + 1 > SAT) ? SAT : v + 1;
  endfunction

  task automatic push(input logic rd, input logic wr, input logic presp,
                      input logic [7:0] tag, input outv_t o);
    step_t s;
    s.rd = rd; s.wr = wr; s.presp = presp; s.tag = tag; s.o = o;
    s.h = exp_hits; s.m = exp_misses;
    trace.push_back(s);
  endtask

  // Expected cycle trace of one complete access, starting from an idle controller.
  task automatic add_txn(input logic we, input logic both, input logic [7:0] tag,
                         input int wb_lat, input int fill_lat);
    outv_t o;
    int    w;
    logic  v;
    logic  rq;
    rq = !we || both;
    w  = -1;
    for (int i = 0; i < 2; i++) if (ref_valid[i] && ref_tag[i] == tag) w = i;
    push(rq, we, 1'b0, tag, dflt());
    if (w < 0) begin
      v = ~ref_mru;
      push(rq, we, 1'b0, tag, dflt());
      exp_misses = sat(exp_misses);
      if (ref_valid[v] && ref_dirty[v])
        for (int k = 0; k < wb_lat; k++) begin
          o = dflt(); o.addr_bit = 1'b1; o.pmem_write = 1'b1;
          push(rq, we, (k == wb_lat - 1), tag, o);
        end
      for (int k = 0; k < fill_lat; k++) begin
        o = dflt(); o.pmem_read = 1'b1;
        if (k == fill_lat - 1) begin
          o.data_bit = 1'b1;
          o.ld_data[v] = 1'b0; o.ld_tag[v] = 1'b0; o.ld_valid[v] = 1'b0; o.ld_dirty[v] = 1'b0;
        end
        push(rq, we, (k == fill_lat - 1), tag, o);
      end
      ref_tag[v] = tag; ref_valid[v] = 1'b1; ref_dirty[v] = 1'b0;
      push(rq, we, 1'b0, tag, dflt());
      w = int'(v);
    end
    o = dflt(); o.mem_resp = 1'b1; o.ld_lru = 1'b0; o.lru_in = w[0];
    if (we) begin
      o.ld_data[w] = 1'b0; o.ld_dirty[w] = 1'b0; o.dirty_in[w] = 1'b1;
      ref_dirty[w] = 1'b1;
    end
    push(rq, we, 1'b0, tag, o);
    exp_hits = sat(exp_hits);
    ref_mru  = w[0];
    push(1'b0, 1'b0, 1'b0, tag, dflt());
  endtask

  task automatic run_trace();
    step_t s;
    while (trace.size() > 0) begin
      s = trace.pop_front();
      @(posedge clk); #1;
      bus.mem_read = s.rd; bus.mem_write = s.wr; bus.pmem_resp = s.presp; cur_tag = s.tag;
      cur = s; chk_en = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk_en = 1'b0;
    bus.pmem_resp = 1'b0;
  endtask

  task automatic check_set(input string name);
    for (int i = 0; i < 2; i++) begin
      cmp({name, "_valid_dirty"}, {30'd0, dp_valid[i], dp_dirty[i]}, {30'd0, ref_valid[i], ref_dirty[i]});
      if (ref_valid[i]) cmp({name, "_tag"}, 32'(dp_tag[i]), 32'(ref_tag[i]));
    end
    cmp({name, "_mru"}, 32'(dp_mru), 32'(ref_mru));
  endtask

  // Per-cycle output check and latency bookkeeping
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        cmp("outputs", 32'(act_out()), 32'(cur.o));
        cmp("hit_count", 32'(hit_count), 32'(cur.h));
        cmp("miss_count", 32'(miss_count), 32'(cur.m));
      end
      if (bus.mem_read || bus.mem_write) req_cyc++;
      if (bus.pmem_read && bus.pmem_resp) fill_cyc = cyc;
      if (bus.mem_resp) begin
        last_lat = req_cyc;
        resp_gap = cyc - fill_cyc;
        req_cyc  = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; req_cyc = 0; last_lat = 0; fill_cyc = 0; resp_gap = 0;
    chk_en = 1'b0; dp_clr = 1'b1; rst = 1'b0; cur_tag = 8'h00;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
    ref_valid = '0; ref_dirty = '0; ref_mru = 1'b0; ref_tag[0] = '0; ref_tag[1] = '0;
    exp_hits = 0; exp_misses = 0;

    repeat (2) @(posedge clk);
    #1 dp_clr = 1'b0;
    @(negedge clk);
    cmp("reset_outputs", 32'(act_out()), 32'(dflt()));
    cmp("reset_hit_count", 32'(hit_count), 32'd0);
    cmp("reset_miss_count", 32'(miss_count), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Read miss into an empty set, line returned after 3 cycles
    add_txn(1'b0, 1'b0, 8'h0A, 1, 3);
    run_trace();
    cmp("t1_hit_count", 32'(hit_count), 32'd1);
    cmp("t1_miss_count", 32'(miss_count), 32'd1);
    cmp("t1_latency", 32'(last_lat), 32'd7);
    cmp("t1_pmem_to_resp", 32'(resp_gap), 32'd2);
    check_set("t1");

    // Read hit on the same line
    add_txn(1'b0, 1'b0, 8'h0A, 1, 1);
    run_trace();
    cmp("t2_latency", 32'(last_lat), 32'd2);
    cmp("t2_hit_count", 32'(hit_count), 32'd2);

    // Write hit with both strobes set, then misses: clean fill, dirty eviction, clean victim
    add_txn(1'b1, 1'b1, 8'h0A, 1, 1);
    add_txn(1'b0, 1'b0, 8'h0B, 1, 2);
    add_txn(1'b0, 1'b0, 8'h0C, 2, 2);
    add_txn(1'b1, 1'b0, 8'h0D, 1, 1);
    run_trace();
    check_set("t3_t6");
    cmp("t6_miss_count", 32'(miss_count), 32'd4);

    // pmem_resp pulses while idle must be ignored; a following read still hits in 2
    push(1'b0, 1'b0, 1'b1, 8'h0D, dflt());
    push(1'b0, 1'b0, 1'b0, 8'h0D, dflt());
    push(1'b0, 1'b0, 1'b1, 8'h0D, dflt());
    add_txn(1'b0, 1'b0, 8'h0D, 1, 1);
    run_trace();
    cmp("t7_latency", 32'(last_lat), 32'd2);
    check_set("t7");

    // Reset asserted while waiting for a fill
    push(1'b1, 1'b0, 1'b0, 8'h0E, dflt());
    push(1'b1, 1'b0, 1'b0, 8'h0E, dflt());
    exp_misses = sat(exp_misses);
    begin
      outv_t o;
      o = dflt(); o.pmem_read = 1'b1;
      push(1'b1, 1'b0, 1'b0, 8'h0E, o);
      push(1'b1, 1'b0, 1'b0, 8'h0E, o);
    end
    run_trace();
    cmp("fill_pmem_read_before_reset", 32'(bus.pmem_read), 32'd1);
    #1 rst = 1'b0;
    #1;
    cmp("reset_mid_fill_outputs", 32'(act_out()), 32'(dflt()));
    cmp("reset_mid_fill_hit_count", 32'(hit_count), 32'd0);
    cmp("reset_mid_fill_miss_count", 32'(miss_count), 32'd0);
    bus.mem_read = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    exp_hits = 0; exp_misses = 0;
    check_set("reset_mid_fill");

    // Nine misses drive both 3-bit counters into saturation
    for (int i = 0; i < 9; i++) add_txn(1'b0, 1'b0, 8'(8'h10 + i), 1, 1);
    run_trace();
    cmp("sat_miss_count", 32'(miss_count), 32'd7);
    cmp("sat_hit_count", 32'(hit_count), 32'd7);
    check_set("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
